// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encoding and defaults for the button conditioner
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } chan_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit for the degenerate case.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one pushbutton channel: synchronizer, debounce FSM, press pulse
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          btn_sync;
    chan_state_t   state_q;
    chan_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_d;

    assign btn_sync = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
        end
    end

    // cnt counts stable samples after the first one; it never advances past CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_d = ST_ARMING;
                    cnt_d   = '0;
                end
            end
            ST_ARMING: begin
                if (!btn_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASING;
                    cnt_d   = '0;
                end
            end
            ST_RELEASING: begin
                if (btn_sync) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == ST_PRESSED) || (state_q == ST_RELEASING);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two independent debounced pushbuttons feeding the sequence detector
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic P1,
    output logic P2,
    output logic p1_level,
    output logic p2_level
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan1 (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn1_raw),
        .pulse  (P1),
        .level  (p1_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan2 (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn2_raw),
        .pulse  (P2),
        .level  (p2_level)
    );

endmodule
